split_4o: RTL and testbench



---
 rtl/split_4o_pkg.sv | 24 ++
 rtl/split_bank.sv | 33 +++
 rtl/split_4o.sv | 176 +++++++++++++++++
 tb/tb_split_4o.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/split_4o_pkg.sv
// Shared types and helpers for the split_4o serial-to-four-lane fan-out.
// Imported by the bank sub-module and the top.
package split_4o_pkg;

    localparam int unsigned NumLanes = 4;

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } state_e;

    // Never returns 0, so a G=1 word index still gets a legal 1-bit vector.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/split_bank.sv
// One ping-pong bank: four lanes of G words, one write port (lane, word) and
// one read port returning the same word of all four lanes.
module split_bank
    import split_4o_pkg::*;
#(
    parameter int unsigned G          = 1,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WordW      = 1
) (
    input  logic                                 clk_i,
    input  logic                                 wr_en_i,
    input  logic [1:0]                           wr_lane_i,
    input  logic [WordW-1:0]                     wr_word_i,
    input  logic [DATA_WIDTH-1:0]                wr_data_i,
    input  logic [WordW-1:0]                     rd_word_i,
    output logic [NumLanes-1:0][DATA_WIDTH-1:0]  rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [NumLanes][G];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_lane_i][wr_word_i] <= wr_data_i;
        end
    end

    always_comb begin
        for (int k = 0; k < NumLanes; k++) begin
            rd_data_o[k] = mem_q[k][rd_word_i];
        end
    end

endmodule

// File: rtl/split_4o.sv
// Deals a serial pixel stream round-robin onto four time-aligned lanes,
// G pixels per lane, through two ping-pong banks and a drain FSM.
module split_4o
    import split_4o_pkg::*;
#(
    parameter int unsigned D          = 220,
    parameter int unsigned G          = 1,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out_1,
    output logic [DATA_WIDTH-1:0] pxl_out_2,
    output logic [DATA_WIDTH-1:0] pxl_out_3,
    output logic [DATA_WIDTH-1:0] pxl_out_4,
    output logic                  valid_out_1,
    output logic                  valid_out_2,
    output logic                  valid_out_3,
    output logic                  valid_out_4
);

    localparam int unsigned WordW   = clog2(G);
    localparam int unsigned RowCntW = clog2(D);
    localparam logic [WordW-1:0]   LastWord = WordW'(G - 1);
    localparam logic [RowCntW-1:0] LastRow  = RowCntW'(D - 1);

    // in_cnt is kept as its (lane, word) decomposition.
    state_e                               state_q, state_d;
    logic                                 drain_bank_q, drain_bank_d;
    logic [WordW-1:0]                     out_cnt_q, out_cnt_d;
    logic [1:0]                           full_q, full_d;
    logic                                 fill_q, fill_d;
    logic [1:0]                           wr_lane_q, wr_lane_d;
    logic [WordW-1:0]                     wr_word_q, wr_word_d;
    logic [RowCntW-1:0]                   row_cnt_q, row_cnt_d;
    logic                                 valid_q, valid_d;
    logic [NumLanes-1:0][DATA_WIDTH-1:0]  pxl_q, pxl_d;

    logic                                 group_end;
    logic [1:0]                           wr_en;
    logic                                 rd_en, rd_bank;
    logic [WordW-1:0]                     rd_word;
    logic [NumLanes-1:0][DATA_WIDTH-1:0]  rd_data [2];
    logic [NumLanes-1:0][DATA_WIDTH-1:0]  rd_sel;

    assign group_end = valid_in && (wr_lane_q == 2'd3) && (wr_word_q == LastWord);
    assign wr_en     = valid_in ? (fill_q ? 2'b10 : 2'b01) : 2'b00;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        split_bank #(
            .G          (G),
            .DATA_WIDTH (DATA_WIDTH),
            .WordW      (WordW)
        ) u_bank (
            .clk_i     (clk),
            .wr_en_i   (wr_en[b]),
            .wr_lane_i (wr_lane_q),
            .wr_word_i (wr_word_q),
            .wr_data_i (pxl_in),
            .rd_word_i (rd_word),
            .rd_data_o (rd_data[b])
        );
    end

    // IDLE reads word 0 of a newly full bank straight away to meet t+1 latency.
    always_comb begin
        rd_en   = 1'b0;
        rd_bank = 1'b0;
        rd_word = '0;
        unique case (state_q)
            StIdle: begin
                rd_en   = |full_q;
                rd_bank = ~full_q[0];
            end
            StDrain: begin
                rd_en   = 1'b1;
                rd_bank = drain_bank_q;
                rd_word = out_cnt_q;
            end
            default: ;
        endcase
    end

    assign rd_sel = rd_bank ? rd_data[1] : rd_data[0];

    always_comb begin
        state_d      = state_q;
        drain_bank_d = drain_bank_q;
        out_cnt_d    = out_cnt_q;
        full_d       = full_q;
        fill_d       = fill_q;
        wr_lane_d    = wr_lane_q;
        wr_word_d    = wr_word_q;
        row_cnt_d    = row_cnt_q;
        valid_d      = 1'b0;
        pxl_d        = pxl_q;

        if (valid_in) begin
            if (wr_word_q == LastWord) begin
                wr_word_d = '0;
                wr_lane_d = wr_lane_q + 2'd1;
            end else begin
                wr_word_d = wr_word_q + WordW'(1);
            end
            row_cnt_d = (row_cnt_q == LastRow) ? '0 : row_cnt_q + RowCntW'(1);
        end

        if (rd_en) begin
            valid_d = 1'b1;
            pxl_d   = rd_sel;
            if (rd_word == LastWord) begin
                full_d[rd_bank] = 1'b0;
                if (full_q[~rd_bank]) begin
                    state_d      = StDrain;
                    drain_bank_d = ~rd_bank;
                    out_cnt_d    = '0;
                end else begin
                    state_d = StIdle;
                end
            end else begin
                state_d      = StDrain;
                drain_bank_d = rd_bank;
                out_cnt_d    = rd_word + WordW'(1);
            end
        end

        if (group_end) begin
            full_d[fill_q] = 1'b1;
            fill_d         = ~fill_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            drain_bank_q <= 1'b0;
            out_cnt_q    <= '0;
            full_q       <= '0;
            fill_q       <= 1'b0;
            wr_lane_q    <= '0;
            wr_word_q    <= '0;
            row_cnt_q    <= '0;
            valid_q      <= 1'b0;
            pxl_q        <= '0;
        end else begin
            state_q      <= state_d;
            drain_bank_q <= drain_bank_d;
            out_cnt_q    <= out_cnt_d;
            full_q       <= full_d;
            fill_q       <= fill_d;
            wr_lane_q    <= wr_lane_d;
            wr_word_q    <= wr_word_d;
            row_cnt_q    <= row_cnt_d;
            valid_q      <= valid_d;
            pxl_q        <= pxl_d;
        end
    end

    assign pxl_out_1   = pxl_q[0];
    assign pxl_out_2   = pxl_q[1];
    assign pxl_out_3   = pxl_q[2];
    assign pxl_out_4   = pxl_q[3];
    assign valid_out_1 = valid_q;
    assign valid_out_2 = valid_q;
    assign valid_out_3 = valid_q;
    assign valid_out_4 = valid_q;

    a_no_overrun: assert property (@(posedge clk) disable iff (reset)
        valid_in |-> !full_q[fill_q]);

    a_row_end_is_group_end: assert property (@(posedge clk) disable iff (reset)
        (valid_in && (row_cnt_q == LastRow)) |-> group_end);

endmodule

// File: tb/tb_split_4o.sv
// Directed bench for split_4o: three instances (G=1/D=8, G=2/D=8, G=4/D=16)
// share clock and reset; a monitor per instance logs every valid output cycle.
module tb_split_4o;

    typedef struct packed {
        logic [31:0]      cyc;
        logic [3:0]       v;
        logic [3:0][31:0] d;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vi [3];
    logic [31:0] pi [3];
    logic [31:0] po [3][4];
    logic        vo [3][4];
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    rec_t        mon_q0 [$];
    rec_t        mon_q1 [$];
    rec_t        mon_q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    split_4o #(.D(8), .G(1), .DATA_WIDTH(32)) u_g1 (
        .clk(clk), .reset(reset), .valid_in(vi[0]), .pxl_in(pi[0]),
        .pxl_out_1(po[0][0]), .pxl_out_2(po[0][1]), .pxl_out_3(po[0][2]),
        .pxl_out_4(po[0][3]), .valid_out_1(vo[0][0]), .valid_out_2(vo[0][1]),
        .valid_out_3(vo[0][2]), .valid_out_4(vo[0][3])
    );

    split_4o #(.D(8), .G(2), .DATA_WIDTH(32)) u_g2 (
        .clk(clk), .reset(reset), .valid_in(vi[1]), .pxl_in(pi[1]),
        .pxl_out_1(po[1][0]), .pxl_out_2(po[1][1]), .pxl_out_3(po[1][2]),
        .pxl_out_4(po[1][3]), .valid_out_1(vo[1][0]), .valid_out_2(vo[1][1]),
        .valid_out_3(vo[1][2]), .valid_out_4(vo[1][3])
    );

    split_4o #(.D(16), .G(4), .DATA_WIDTH(32)) u_g4 (
        .clk(clk), .reset(reset), .valid_in(vi[2]), .pxl_in(pi[2]),
        .pxl_out_1(po[2][0]), .pxl_out_2(po[2][1]), .pxl_out_3(po[2][2]),
        .pxl_out_4(po[2][3]), .valid_out_1(vo[2][0]), .valid_out_2(vo[2][1]),
        .valid_out_3(vo[2][2]), .valid_out_4(vo[2][3])
    );

    function automatic rec_t mk_rec(input int i);
        rec_t r;
        r.cyc = cyc;
        for (int k = 0; k < 4; k++) begin
            r.v[k] = vo[i][k];
            r.d[k] = po[i][k];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (vo[0][0] | vo[0][1] | vo[0][2] | vo[0][3]) mon_q0.push_back(mk_rec(0));
        if (vo[1][0] | vo[1][1] | vo[1][2] | vo[1][3]) mon_q1.push_back(mk_rec(1));
        if (vo[2][0] | vo[2][1] | vo[2][2] | vo[2][3]) mon_q2.push_back(mk_rec(2));
    end

    // Presents one pixel; acc returns the number of the edge that accepted it.
    task automatic drive(input int sel, input logic [31:0] val, input bit gap,
                         output int unsigned acc);
        vi[sel] = 1'b1;
        pi[sel] = val;
        @(posedge clk);
        #1;
        acc = cyc;
        if (gap) begin
            vi[sel] = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (vo[i][k] !== 1'b0 || po[i][k] !== 32'd0) begin
                    n_err++;
                    $display("FAIL reset_in inst%0d lane%0d: valid=%b pxl=%0d, want 0/0",
                             i, k + 1, vo[i][k], po[i][k]);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (vo[i][0] !== 1'b0 || po[i][0] !== 32'd0) begin
                n_err++;
                $display("FAIL reset_after inst%0d: valid=%b pxl=%0d, want 0/0",
                         i, vo[i][0], po[i][0]);
            end
        end
    endtask

    task automatic test_g1();
        int unsigned acc, t4, t8;
        rec_t r;
        mon_q0.delete();
        for (int v = 1; v <= 8; v++) begin
            drive(0, 32'(v), 1'b0, acc);
            if (v == 4) t4 = acc;
            if (v == 8) t8 = acc;
        end
        vi[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (mon_q0.size() != 2) begin
            n_err++;
            $display("FAIL g1_count: got %0d bursts, want 2", mon_q0.size());
        end
        for (int b = 0; b < 2; b++) begin
            if (b < mon_q0.size()) begin
                r = mon_q0[b];
                n_cmp++;
                if (r.cyc !== ((b == 0) ? t4 : t8) + 1 || r.v !== 4'hf) begin
                    n_err++;
                    $display("FAIL g1_timing burst%0d: edge=%0d v=%b, want edge=%0d v=1111",
                             b, r.cyc, r.v, ((b == 0) ? t4 : t8) + 1);
                end
                for (int k = 0; k < 4; k++) begin
                    n_cmp++;
                    if (r.d[k] !== 32'(4 * b + k + 1)) begin
                        n_err++;
                        $display("FAIL g1_data burst%0d lane%0d: got %0d, want %0d",
                                 b, k + 1, r.d[k], 4 * b + k + 1);
                    end
                end
            end
        end
    endtask

    // One or two G=4 groups with values base+i; gap selects every-other-cycle valid.
    task automatic test_g4(input bit gap, input int ngrp, input int unsigned base);
        int unsigned acc;
        int unsigned tend [2];
        rec_t r;
        mon_q2.delete();
        for (int i = 0; i < 16 * ngrp; i++) begin
            drive(2, 32'(base + i), gap, acc);
            if (i % 16 == 15) tend[i / 16] = acc;
        end
        vi[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (mon_q2.size() != 4 * ngrp) begin
            n_err++;
            $display("FAIL g4_count gap=%0d: got %0d words, want %0d",
                     gap, mon_q2.size(), 4 * ngrp);
        end
        for (int n = 0; n < 4 * ngrp; n++) begin
            if (n < mon_q2.size()) begin
                r = mon_q2[n];
                n_cmp++;
                if (r.cyc !== tend[n / 4] + 1 + n % 4 || r.v !== 4'hf) begin
                    n_err++;
                    $display("FAIL g4_timing gap=%0d word%0d: edge=%0d v=%b, want edge=%0d",
                             gap, n, r.cyc, r.v, tend[n / 4] + 1 + n % 4);
                end
                for (int k = 0; k < 4; k++) begin
                    n_cmp++;
                    if (r.d[k] !== 32'(base + 16 * (n / 4) + 4 * k + n % 4)) begin
                        n_err++;
                        $display("FAIL g4_data gap=%0d word%0d lane%0d: got %0d, want %0d",
                                 gap, n, k + 1, r.d[k], base + 16 * (n / 4) + 4 * k + n % 4);
                    end
                end
            end
        end
    endtask

    task automatic test_rows();
        int unsigned acc;
        int unsigned tend [6];
        rec_t r;
        mon_q1.delete();
        for (int i = 0; i < 24; i++) begin
            drive(1, 32'(i), 1'b0, acc);
            if (i % 8 == 7) tend[i / 8] = acc;
        end
        vi[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (mon_q1.size() != 6) begin
            n_err++;
            $display("FAIL rows_count: got %0d words, want 6", mon_q1.size());
        end
        for (int n = 0; n < 6; n++) begin
            if (n < mon_q1.size()) begin
                r = mon_q1[n];
                n_cmp++;
                if (r.cyc !== tend[n / 2] + 1 + n % 2 || r.v !== 4'hf) begin
                    n_err++;
                    $display("FAIL rows_timing word%0d: edge=%0d v=%b, want edge=%0d",
                             n, r.cyc, r.v, tend[n / 2] + 1 + n % 2);
                end
                for (int k = 0; k < 4; k++) begin
                    n_cmp++;
                    if (r.d[k] !== 32'(8 * (n / 2) + 2 * k + n % 2)) begin
                        n_err++;
                        $display("FAIL rows_data word%0d lane%0d: got %0d, want %0d",
                                 n, k + 1, r.d[k], 8 * (n / 2) + 2 * k + n % 2);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_partial();
        int unsigned acc;
        for (int i = 0; i < 6; i++) drive(2, 32'(50 + i), 1'b0, acc);
        vi[2] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        test_g4(1'b0, 1, 100);
    endtask

    task automatic test_reset_drain();
        int unsigned acc;
        mon_q2.delete();
        for (int i = 0; i < 16; i++) drive(2, 32'(200 + i), 1'b0, acc);
        vi[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (vo[2][0] !== 1'b1 || po[2][0] !== 32'd201) begin
            n_err++;
            $display("FAIL drain_second_word: valid=%b lane1=%0d, want 1/201",
                     vo[2][0], po[2][0]);
        end
        reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (vo[2][k] !== 1'b0 || po[2][k] !== 32'd0) begin
                n_err++;
                $display("FAIL reset_async lane%0d: valid=%b pxl=%0d, want 0/0",
                         k + 1, vo[2][k], po[2][k]);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (mon_q2.size() != 2) begin
            n_err++;
            $display("FAIL reset_drain_quiet: got %0d words, want 2", mon_q2.size());
        end
        test_g4(1'b0, 1, 300);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vi[i] = 1'b0;
            pi[i] = '0;
        end
        test_reset();
        test_g1();
        test_g4(1'b0, 1, 0);
        test_g4(1'b1, 2, 0);
        test_rows();
        test_reset_partial();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
